sha256_sequencer: RTL and testbench
===================================

# sha256_sequencer

Drives the SHA-256 compression core: pads a byte message of 0..119 bytes into one or two 512-bit blocks and generates the core's `state`/`flag`/`indice` control sequence. Presents each `chunk`, chains blocks, and captures the core's `HASH` as the final digest. Sits between the mining controller, which supplies header bytes, and the SHA-256 core.

## Interface
- MAX_BYTES, 119, maximum message length in bytes (fixed; two-block limit).
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- msg  in  952  message; byte 0 at msg[951:944], byte n at msg[951-8n -: 8].
- msg_len  in  7  message length in bytes, 0..119.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when digest is valid.
- digest  out  256  final hash; holds until the next done or reset.
- err  out  1  one-cycle pulse when msg_len > 119.
- state  out  3  core phase code.
- flag  out  1  core sub-phase select.
- indice  out  6  round index for the core.
- chunk  out  512  padded block to the core; word 0 at [511:480].
- HASH  in  256  core result; valid after a state=6 cycle.

## Operation
- Reset (reset=0 at an edge): FSM goes to IDLE. state=0, flag=0, indice=0, chunk=0, busy=0, done=0, err=0, digest=0. Reset overrides any in-progress hash; no done is produced for the aborted message.
- Padding per block:
  - Message bytes, then 0x80, then zeros.
  - Last 64 bits of the final block = 8*msg_len, big-endian.
  - nblocks = 1 if msg_len ≤ 55, else 2.
  - Padding is formed from msg/msg_len registered at start; input changes afterwards are ignored.
- FSM states and core codes driven:
  - IDLE: state=0.
  - INIT: state=2; one cycle, first block only.
  - LOAD: state=4, flag=0; one cycle.
  - EXPAND: state=4, flag=1; one cycle.
  - ROUND: state=5; 128 cycles. Round r (0..63) spans two cycles with indice=r, flag=0 then flag=1. After r=63/flag=1, go to GAP if another block remains, else to OUT.
  - GAP: state=3; one cycle. Switch chunk to block 1, then go to LOAD. INIT is skipped so the core chains its hash values.
  - OUT: state=6; one cycle.
  - CAPTURE: state=7; one cycle. digest<=HASH at the end of this cycle.
  - DONE: state=0; done=1 for one cycle, busy=0; return to IDLE.
- chunk holds the current block stable from LOAD through the last ROUND cycle of that block.
- flag=0 and indice=0 in every state not listed above.
- start while busy: ignored, no queueing.
- start with msg_len>119: err=1 in the next cycle, FSM stays in IDLE, busy stays 0.
- start and reset low in the same cycle: reset wins.

## Timing
- start accepted at edge T. INIT occupies cycle T+1; busy=1 from T+1.
- One block:
  - LOAD T+2, EXPAND T+3, ROUND T+4..T+131, OUT T+132, CAPTURE T+133.
  - done=1 and digest valid in cycle T+134. Latency 134.
- Two blocks:
  - Block 0 rounds end at T+131, GAP T+132, LOAD T+133, EXPAND T+134, ROUND T+135..T+262, OUT T+263, CAPTURE T+264.
  - done at T+265.
- Next start is accepted in the cycle after done, at the earliest.

## Test plan
- "abc", msg_len=3, with the SHA core attached:
  - digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
  - done exactly at T+134.
  - chunk=61626380 00000000 … 00000018.
- msg_len=0:
  - digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
  - block 0 word 0 = 80000000, last word = 0.
- 56-byte "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - two blocks, GAP at T+132, no second state=2 cycle.
  - digest=248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, done at T+265.
- Protocol monitor over the run:
  - ROUND: indice increments once per two cycles, with flag sequence 0,1.
  - chunk stable per block; state sequence exactly 2,4,4,5×128,6,7,0.
- msg_len=120 → err pulse at T+1; busy, done and state stay 0. start pulsed at T+50 (during an "abc" run) → ignored; single done at T+134.
- reset=0 at T+70 mid-ROUND → next cycle all outputs at reset values; a fresh "abc" start afterwards yields the correct digest.

Source files
------------

// File: rtl/sha256_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sequencer_if
// Description : Bundle between the mining controller / SHA-256 core side
//               (master) and the sha256_sequencer (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface sha256_sequencer_if;
    logic         start;
    logic [951:0] msg;
    logic [6:0]   msg_len;
    logic         busy;
    logic         done;
    logic [255:0] digest;
    logic         err;
    logic [2:0]   state;
    logic         flag;
    logic [5:0]   indice;
    logic [511:0] chunk;
    logic [255:0] HASH;

    modport master (
        output start, msg, msg_len, HASH,
        input  busy, done, digest, err, state, flag, indice, chunk
    );

    modport slave (
        input  start, msg, msg_len, HASH,
        output busy, done, digest, err, state, flag, indice, chunk
    );
endinterface
`default_nettype wire

// File: rtl/sha256_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sha256_sequencer
// Description : Pads a 0..119 byte message into one or two 512-bit blocks,
//               sequences the SHA-256 core's state/flag/indice controls,
//               chains blocks and captures the core HASH as the digest.
// Revision    : 1.0 - initial release
// ============================================================================
module sha256_sequencer (
    input logic               clock,
    input logic               reset,
    sha256_sequencer_if.slave bus
);

    localparam logic [6:0] c_MAX_BYTES     = 7'd119;
    localparam logic [6:0] c_ONE_BLOCK_MAX = 7'd55;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_INIT    = 4'd1,
        S_LOAD    = 4'd2,
        S_EXPAND  = 4'd3,
        S_ROUND   = 4'd4,
        S_GAP     = 4'd5,
        S_OUT     = 4'd6,
        S_CAPTURE = 4'd7,
        S_DONE    = 4'd8
    } fsm_t;

    fsm_t          r_fsm;
    logic [951:0]  r_msg;
    logic [6:0]    r_len;
    logic          r_two;
    logic          r_blk;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic [2:0]    r_state;
    logic          r_flag;
    logic [5:0]    r_indice;
    logic [511:0]  r_chunk;
    logic [255:0]  r_digest;

    // Message widened to 128 bytes so every padded byte position has a source slice.
    logic [1023:0] w_ext;
    logic [1023:0] w_pad;

    assign w_ext = {r_msg, 72'd0};

    // Build both padded blocks from the captured message: bytes, 0x80, zeros, bit length.
    always_comb begin
        w_pad = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < int'(r_len)) begin
                w_pad[1023 - 8*i -: 8] = w_ext[1023 - 8*i -: 8];
            end else if (i == int'(r_len)) begin
                w_pad[1023 - 8*i -: 8] = 8'h80;
            end
        end
        if (r_two) begin
            w_pad[63:0] = {54'd0, r_len, 3'd0};
        end else begin
            w_pad[575:512] = {54'd0, r_len, 3'd0};
        end
    end

    // Control FSM; every core-facing output is registered alongside the state change.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fsm    <= S_IDLE;
            r_msg    <= '0;
            r_len    <= '0;
            r_two    <= 1'b0;
            r_blk    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_state  <= 3'd0;
            r_flag   <= 1'b0;
            r_indice <= 6'd0;
            r_chunk  <= '0;
            r_digest <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    r_state  <= 3'd0;
                    r_flag   <= 1'b0;
                    r_indice <= 6'd0;
                    if (bus.start) begin
                        if (bus.msg_len > c_MAX_BYTES) begin
                            r_err <= 1'b1;
                        end else begin
                            r_msg   <= bus.msg;
                            r_len   <= bus.msg_len;
                            r_two   <= (bus.msg_len > c_ONE_BLOCK_MAX);
                            r_blk   <= 1'b0;
                            r_busy  <= 1'b1;
                            r_state <= 3'd2;
                            r_fsm   <= S_INIT;
                        end
                    end
                end
                S_INIT: begin
                    r_chunk <= w_pad[1023:512];
                    r_state <= 3'd4;
                    r_flag  <= 1'b0;
                    r_fsm   <= S_LOAD;
                end
                S_LOAD: begin
                    r_state <= 3'd4;
                    r_flag  <= 1'b1;
                    r_fsm   <= S_EXPAND;
                end
                S_EXPAND: begin
                    r_state  <= 3'd5;
                    r_flag   <= 1'b0;
                    r_indice <= 6'd0;
                    r_fsm    <= S_ROUND;
                end
                S_ROUND: begin
                    if (!r_flag) begin
                        r_flag <= 1'b1;
                    end else if (r_indice != 6'd63) begin
                        r_flag   <= 1'b0;
                        r_indice <= r_indice + 6'd1;
                    end else begin
                        r_flag   <= 1'b0;
                        r_indice <= 6'd0;
                        if (r_two && !r_blk) begin
                            // Second block chains off the core's hash; no INIT.
                            r_blk   <= 1'b1;
                            r_chunk <= w_pad[511:0];
                            r_state <= 3'd3;
                            r_fsm   <= S_GAP;
                        end else begin
                            r_state <= 3'd6;
                            r_fsm   <= S_OUT;
                        end
                    end
                end
                S_GAP: begin
                    r_state <= 3'd4;
                    r_flag  <= 1'b0;
                    r_fsm   <= S_LOAD;
                end
                S_OUT: begin
                    r_state <= 3'd7;
                    r_fsm   <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    r_digest <= bus.HASH;
                    r_state  <= 3'd0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_fsm    <= S_DONE;
                end
                S_DONE: begin
                    r_fsm <= S_IDLE;
                end
                default: begin
                    r_state <= 3'd0;
                    r_busy  <= 1'b0;
                    r_fsm   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.err    = r_err;
    assign bus.state  = r_state;
    assign bus.flag   = r_flag;
    assign bus.indice = r_indice;
    assign bus.chunk  = r_chunk;
    assign bus.digest = r_digest;

endmodule
`default_nettype wire

// File: tb/tb_sha256_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha256_sequencer
// Description : Self-checking bench for sha256_sequencer with a behavioural
//               SHA-256 core and a byte-level SHA-256 reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha256_sequencer;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    sha256_sequencer_if bus();

    sha256_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mbytes [0:118];

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef struct packed {
        logic [2:0] st;
        logic       fl;
        logic [5:0] ix;
        logic [1:0] blk;   // 0/1: chunk must equal that block, 2: not checked
    } step_t;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96]  + e, hin[95:64]   + f, hin[63:32]   + g, hin[31:0]    + h};
    endfunction

    // Padded block b of the len-byte message in mbytes, built as a byte array.
    function automatic logic [511:0] pad_block(input int len, input int b);
        logic [7:0]   p [128];
        logic [63:0]  bits;
        logic [511:0] blk;
        int           nb;
        for (int i = 0; i < 128; i++) p[i] = 8'h00;
        for (int i = 0; i < len; i++) p[i] = mbytes[i];
        p[len] = 8'h80;
        nb   = (len + 9 > 64) ? 2 : 1;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) p[nb*64 - 1 - k] = 8'(bits >> (8*k));
        for (int j = 0; j < 64; j++) blk[511 - 8*j -: 8] = p[64*b + j];
        return blk;
    endfunction

    function automatic logic [255:0] sha_ref(input int len);
        logic [255:0] h;
        h = compress(IV, pad_block(len, 0));
        if (len + 9 > 64) h = compress(h, pad_block(len, 1));
        return h;
    endfunction

    function automatic step_t mk(input int st, input int fl, input int ix, input int blk);
        step_t s;
        s.st  = 3'(st);
        s.fl  = 1'(fl);
        s.ix  = 6'(ix);
        s.blk = 2'(blk);
        return s;
    endfunction

    function automatic logic [951:0] pack_msg();
        logic [951:0] v;
        for (int n = 0; n < 119; n++) v[951 - 8*n -: 8] = mbytes[n];
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 119; i++) mbytes[i] = 8'($urandom);
    endtask

    task automatic set_str(input string s);
        fill_random();
        for (int i = 0; i < s.len(); i++) mbytes[i] = s[i];
    endtask

    // Behavioural SHA-256 core: IV on state 2, one compression after round 63/flag 1,
    // result presented on HASH after a state 6 cycle.
    logic [255:0] core_h = '0;
    always @(posedge clock) begin
        if (bus.state == 3'd2)
            core_h <= IV;
        else if (bus.state == 3'd5 && bus.flag && bus.indice == 6'd63)
            core_h <= compress(core_h, bus.chunk);
        if (bus.state == 3'd6)
            bus.HASH <= core_h;
    end

    // One full hash; the expected cycle-by-cycle control sequence is built from the
    // phase list, and every cycle is compared against it.
    task automatic run_msg(input int len, input int poke,
                           output logic [255:0] dig, output logic [511:0] ch0,
                           output int done_k, output int gap_k, output int n_init);
        step_t        q[$];
        step_t        e;
        int           nb, bad_seq, bad_chunk, n_done;
        logic [511:0] blk0, blk1;
        logic [255:0] want_d;
        nb = (len + 9 > 64) ? 2 : 1;
        q.push_back(mk(2, 0, 0, 2));
        for (int b = 0; b < nb; b++) begin
            if (b > 0) q.push_back(mk(3, 0, 0, 2));
            q.push_back(mk(4, 0, 0, b));
            q.push_back(mk(4, 1, 0, b));
            for (int r = 0; r < 64; r++) begin
                q.push_back(mk(5, 0, r, b));
                q.push_back(mk(5, 1, r, b));
            end
        end
        q.push_back(mk(6, 0, 0, 2));
        q.push_back(mk(7, 0, 0, 2));
        q.push_back(mk(0, 0, 0, 2));
        blk0   = pad_block(len, 0);
        blk1   = pad_block(len, 1);
        want_d = sha_ref(len);
        bad_seq = 0; bad_chunk = 0; n_done = 0;
        done_k = 0; gap_k = 0; n_init = 0; ch0 = '0;

        @(negedge clock);
        bus.msg     = pack_msg();
        bus.msg_len = 7'(len);
        bus.start   = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        for (int n = 0; n < 119; n++) bus.msg[951 - 8*n -: 8] = 8'($urandom);
        bus.msg_len = 7'($urandom_range(0, 119));

        for (int k = 1; k <= q.size() + 3; k++) begin
            if (bus.state == 3'd3 && gap_k == 0) gap_k = k;
            if (bus.state == 3'd2) n_init++;
            if (bus.done) begin
                n_done++;
                if (done_k == 0) done_k = k;
            end
            if (k == 2) ch0 = bus.chunk;
            if (k <= q.size()) begin
                e = q[k-1];
                if (bus.state !== e.st || bus.flag !== e.fl || bus.indice !== e.ix ||
                    bus.busy !== (k < q.size()) || bus.done !== (k == q.size()) ||
                    bus.err !== 1'b0)
                    bad_seq++;
                if (e.blk != 2'd2 && bus.chunk !== ((e.blk == 2'd0) ? blk0 : blk1))
                    bad_chunk++;
            end else if (bus.state !== 3'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
                bad_seq++;
            end
            bus.start = (k == poke);
            @(negedge clock);
        end
        bus.start = 1'b0;
        dig = bus.digest;
        chk("state_seq", 256'(bad_seq), 256'd0);
        chk("chunk_stable", 256'(bad_chunk), 256'd0);
        chk("done_cycle", 256'(done_k), 256'(q.size()));
        chk("done_count", 256'(n_done), 256'd1);
        chk("digest_ref", dig, want_d);
    endtask

    initial begin
        logic [255:0] dig;
        logic [511:0] ch0;
        int           done_k, gap_k, n_init, cnt, len;

        reset = 1'b0;
        bus.start = 1'b0;
        bus.msg = '0;
        bus.msg_len = 7'd0;
        repeat (3) @(negedge clock);
        chk("rst_state", 256'(bus.state), 256'd0);
        chk("rst_busy", 256'(bus.busy), 256'd0);
        chk("rst_done", 256'(bus.done), 256'd0);
        chk("rst_chunk", 256'(bus.chunk), 256'd0);
        chk("rst_digest", bus.digest, 256'd0);
        reset = 1'b1;
        @(negedge clock);

        // "abc" with a stray start at T+50
        set_str("abc");
        run_msg(3, 50, dig, ch0, done_k, gap_k, n_init);
        chk("abc_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        chk("abc_done_at", 256'(done_k), 256'd134);
        chk("abc_chunk", 256'(ch0[511:256]), 256'h6162638000000000000000000000000000000000000000000000000000000000);
        chk("abc_chunk_lo", 256'(ch0[255:0]), 256'h18);

        // empty message
        fill_random();
        run_msg(0, 0, dig, ch0, done_k, gap_k, n_init);
        chk("empty_digest", dig, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
        chk("empty_w0", 256'(ch0[511:480]), 256'h80000000);
        chk("empty_wlast", 256'(ch0[31:0]), 256'h0);

        // 56 bytes: two blocks
        set_str("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
        run_msg(56, 0, dig, ch0, done_k, gap_k, n_init);
        chk("b56_digest", dig, 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1);
        chk("b56_gap_at", 256'(gap_k), 256'd132);
        chk("b56_init_cycles", 256'(n_init), 256'd1);
        chk("b56_done_at", 256'(done_k), 256'd265);

        // oversize lengths give a single err pulse and nothing else
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            bus.msg_len = (i == 0) ? 7'd120 : 7'($urandom_range(120, 127));
            bus.start   = 1'b1;
            @(negedge clock);
            bus.start = 1'b0;
            chk("err_pulse", 256'(bus.err), 256'd1);
            chk("err_busy", 256'({bus.busy, bus.done, bus.state}), 256'd0);
            @(negedge clock);
            chk("err_after", 256'({bus.err, bus.busy, bus.done, bus.state}), 256'd0);
        end

        // reset in the middle of the rounds, then a fresh hash
        set_str("abc");
        @(negedge clock);
        bus.msg     = pack_msg();
        bus.msg_len = 7'd3;
        bus.start   = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        repeat (69) @(negedge clock);
        chk("pre_rst_round", 256'(bus.state), 256'd5);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_rst_ctrl", 256'({bus.state, bus.flag, bus.indice}), 256'd0);
        chk("mid_rst_flags", 256'({bus.busy, bus.done, bus.err}), 256'd0);
        chk("mid_rst_chunk", 256'(bus.chunk), 256'd0);
        chk("mid_rst_digest", bus.digest, 256'd0);
        reset = 1'b1;
        cnt = 0;
        for (int k = 0; k < 200; k++) begin
            if (bus.done || bus.busy) cnt++;
            @(negedge clock);
        end
        chk("abort_quiet", 256'(cnt), 256'd0);
        set_str("abc");
        run_msg(3, 0, dig, ch0, done_k, gap_k, n_init);
        chk("abc2_digest", dig, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        // start together with reset: reset wins
        @(negedge clock);
        bus.msg_len = 7'd3;
        bus.start   = 1'b1;
        reset       = 1'b0;
        @(negedge clock);
        bus.start = 1'b0;
        reset     = 1'b1;
        chk("rst_start_busy", 256'({bus.busy, bus.state}), 256'd0);
        @(negedge clock);
        chk("rst_start_idle", 256'({bus.busy, bus.state}), 256'd0);

        // boundary and random lengths
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: len = 55;
                1: len = 56;
                2: len = 119;
                3: len = 1;
                default: len = int'($urandom_range(0, 119));
            endcase
            fill_random();
            run_msg(len, (i == 5) ? int'($urandom_range(5, 120)) : 0, dig, ch0, done_k, gap_k, n_init);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
